// File: rtl/uart_pkg.sv
// uart_pkg: shared UART receiver state encoding and default frame/oversample constants.
package uart_pkg;
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, BREAK} rx_state_t;
  localparam int DEF_DATA_BITS  = 8;
  localparam int DEF_OVERSAMPLE = 16;
endpackage

// File: rtl/uart_rx_sync.sv
// uart_rx_sync: STAGES-deep synchroniser for an idle-high async input, resetting to 1.
module uart_rx_sync #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic i_d,
  output logic o_q
);
  logic [STAGES-1:0] r_sync;
  always_ff @(posedge clk) begin
    if (rst) r_sync <= '1;
    else     r_sync <= {r_sync[STAGES-2:0], i_d};
  end
  assign o_q = r_sync[STAGES-1];
endmodule

// File: rtl/uart_rx_oversampled.sv
// uart_rx_oversampled: 16x-oversampled UART receiver with mid-bit sampling and 1-cycle result pulses.
// Define UART_RX_PARITY_EN to add a parity bit after the data bits (sense set by PARITY_ODD).
module uart_rx_oversampled
  import uart_pkg::*;
#(
  parameter int DATA_BITS   = DEF_DATA_BITS,
  parameter int OVERSAMPLE  = DEF_OVERSAMPLE,
  parameter int SYNC_STAGES = 2,
  parameter bit PARITY_ODD  = 1'b0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rxClk,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] dataOut,
  output logic                 dataValid,
  output logic                 frameError,
  output logic                 parityError,
  output logic                 busy
);
  localparam int TW = $clog2(OVERSAMPLE);
  localparam int BW = $clog2(DATA_BITS + 1);
  localparam logic [TW-1:0] HALF = TW'(OVERSAMPLE / 2 - 1);
  localparam logic [TW-1:0] FULL = TW'(OVERSAMPLE - 1);
  localparam logic [BW-1:0] LAST = BW'(DATA_BITS - 1);
  rx_state_t r_state, w_state;
  logic [TW-1:0] r_tick_cnt, w_tick_cnt;
  logic [BW-1:0] r_bit_cnt, w_bit_cnt;
  logic [DATA_BITS-1:0] r_shreg, w_shreg, r_data, w_data;
  logic r_valid, w_valid, r_ferr, w_ferr, r_perr, w_perr;
  logic r_rxclk_q, w_tick, w_rxs, w_par_ok;
`ifdef UART_RX_PARITY_EN
  localparam rx_state_t AFTER_DATA = PARITY;
  logic r_par, w_par;
  assign w_par_ok = r_par == (^r_shreg ^ PARITY_ODD);
`else
  localparam rx_state_t AFTER_DATA = STOP;
  assign w_par_ok = 1'b1 | PARITY_ODD;
`endif
  uart_rx_sync #(.STAGES(SYNC_STAGES)) u_sync (.clk(clk), .rst(rst), .i_d(rx), .o_q(w_rxs));
  assign w_tick = rxClk & ~r_rxclk_q;
  // After START, every later state samples one full bit period after the previous mid-bit.
  always_comb begin
    w_state    = r_state;
    w_tick_cnt = r_tick_cnt;
    w_bit_cnt  = r_bit_cnt;
    w_shreg    = r_shreg;
    w_data     = r_data;
    w_valid    = 1'b0;
    w_ferr     = 1'b0;
    w_perr     = 1'b0;
`ifdef UART_RX_PARITY_EN
    w_par      = r_par;
`endif
    if (w_tick) begin
      case (r_state)
        IDLE: begin
          w_state    = w_rxs ? IDLE : START;
          w_tick_cnt = '0;
        end
        START: begin
          w_tick_cnt = (r_tick_cnt == HALF) ? '0 : r_tick_cnt + 1'b1;
          w_bit_cnt  = '0;
          if (r_tick_cnt == HALF) w_state = w_rxs ? IDLE : DATA;
        end
        DATA: begin
          w_tick_cnt = (r_tick_cnt == FULL) ? '0 : r_tick_cnt + 1'b1;
          if (r_tick_cnt == FULL) begin
            w_shreg   = {w_rxs, r_shreg[DATA_BITS-1:1]};
            w_bit_cnt = r_bit_cnt + 1'b1;
            w_state   = (r_bit_cnt == LAST) ? AFTER_DATA : DATA;
          end
        end
`ifdef UART_RX_PARITY_EN
        PARITY: begin
          w_tick_cnt = (r_tick_cnt == FULL) ? '0 : r_tick_cnt + 1'b1;
          if (r_tick_cnt == FULL) begin
            w_par   = w_rxs;
            w_state = STOP;
          end
        end
`endif
        STOP: begin
          w_tick_cnt = (r_tick_cnt == FULL) ? '0 : r_tick_cnt + 1'b1;
          if (r_tick_cnt == FULL) begin
            w_ferr  = ~w_rxs;
            w_perr  = w_rxs & ~w_par_ok;
            w_valid = w_rxs & w_par_ok;
            w_data  = (w_rxs & w_par_ok) ? r_shreg : r_data;
            w_state = w_rxs ? IDLE : BREAK;
          end
        end
        BREAK: w_state = w_rxs ? IDLE : BREAK;
        default: w_state = IDLE;
      endcase
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= IDLE;
      r_tick_cnt <= '0;
      r_bit_cnt  <= '0;
      r_shreg    <= '0;
      r_data     <= '0;
      r_valid    <= 1'b0;
      r_ferr     <= 1'b0;
      r_perr     <= 1'b0;
      r_rxclk_q  <= 1'b0;
`ifdef UART_RX_PARITY_EN
      r_par      <= 1'b0;
`endif
    end else begin
      r_state    <= w_state;
      r_tick_cnt <= w_tick_cnt;
      r_bit_cnt  <= w_bit_cnt;
      r_shreg    <= w_shreg;
      r_data     <= w_data;
      r_valid    <= w_valid;
      r_ferr     <= w_ferr;
      r_perr     <= w_perr;
      r_rxclk_q  <= rxClk;
`ifdef UART_RX_PARITY_EN
      r_par      <= w_par;
`endif
    end
  end
  assign dataOut     = r_data;
  assign dataValid   = r_valid;
  assign frameError  = r_ferr;
  assign parityError = r_perr;
  assign busy        = r_state != IDLE;
endmodule

// File: tb/tb_uart_rx_oversampled.sv
// tb_uart_rx_oversampled: randomized and directed frames checked every cycle against a tick-index frame model.
module tb_uart_rx_oversampled;
  localparam int OS = 16;
  localparam int DB = 8;
  localparam int BITCLK = 64;
`ifdef UART_RX_PARITY_EN
  localparam int PB = 1;
`else
  localparam int PB = 0;
`endif
  logic clk = 1'b0, rst = 1'b1, rxClk = 1'b0, rx = 1'b1;
  logic [7:0] dataOut;
  logic dataValid, frameError, parityError, busy;
  int checks = 0, fails = 0;
  int nv = 0, nf = 0, np = 0;
  bit saw_busy = 0;
  uart_rx_oversampled dut (
    .clk(clk), .rst(rst), .rxClk(rxClk), .rx(rx), .dataOut(dataOut),
    .dataValid(dataValid), .frameError(frameError), .parityError(parityError), .busy(busy)
  );
  always #5 clk = ~clk;
  initial forever begin
    repeat (2) @(negedge clk);
    rxClk = ~rxClk;
  end
  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s actual=%0h expected=%0h t=%0t", nm, act, exp, $time);
    end
  endtask
  // Reference: frame events located by tick index relative to the start-detect tick.
  int n = 0, t0 = 0, mode = 0;
  logic [7:0] m_sh = '0;
  logic m_par = 1'b0;
  logic [1:0] h = 2'b11;
  logic pclk = 1'b0;
  logic e_valid = 0, e_ferr = 0, e_perr = 0, e_busy = 0;
  logic [7:0] e_data = '0;
  always @(posedge clk) begin
    logic s, tk;
    int k, j;
    if (rst) begin
      mode = 0; h = 2'b11; pclk = 1'b0; n = 0;
      e_valid = 0; e_ferr = 0; e_perr = 0; e_busy = 0; e_data = '0;
    end else begin
      s = h[1]; h = {h[0], rx};
      tk = rxClk & ~pclk; pclk = rxClk;
      e_valid = 0; e_ferr = 0; e_perr = 0;
      if (tk) begin
        n++;
        if (mode == 0) begin
          if (!s) begin mode = 1; t0 = n; end
        end else if (mode == 2) begin
          if (s) mode = 0;
        end else begin
          k = n - t0;
          if (k == OS / 2) begin
            if (s) mode = 0;
          end else if (k > OS / 2 && (k - OS / 2) % OS == 0) begin
            j = (k - OS / 2) / OS;
            if (j <= DB) m_sh[j-1] = s;
            else if (j <= DB + PB) m_par = s;
            else if (!s) begin e_ferr = 1; mode = 2; end
            else if (PB == 1 && m_par != ^m_sh) begin e_perr = 1; mode = 0; end
            else begin e_valid = 1; e_data = m_sh; mode = 0; end
          end
        end
      end
      e_busy = mode != 0;
    end
  end
  always @(negedge clk) begin
    check("dataValid", dataValid, e_valid);
    check("frameError", frameError, e_ferr);
    check("parityError", parityError, e_perr);
    check("busy", busy, e_busy);
    check("dataOut", dataOut, e_data);
    nv += dataValid; nf += frameError; np += parityError;
    if (busy) saw_busy = 1;
  end
  task automatic idle(input int c);
    rx = 1'b1;
    repeat (c) @(negedge clk);
  endtask
  task automatic send(input logic [7:0] b, input logic stop, input logic pbit);
    rx = 1'b0;
    repeat (BITCLK) @(negedge clk);
    for (int i = 0; i < DB; i++) begin
      rx = b[i];
      repeat (BITCLK) @(negedge clk);
    end
    if (PB == 1) begin
      rx = pbit;
      repeat (BITCLK) @(negedge clk);
    end
    rx = stop;
    repeat (BITCLK) @(negedge clk);
  endtask
  initial begin
    int v0, f0, p0;
    logic [7:0] b;
    repeat (5) @(negedge clk);
    check("rst_dataOut", dataOut, 8'h00);
    check("rst_busy", busy, 1'b0);
    check("rst_valid", dataValid, 1'b0);
    rst = 1'b0;
    idle(20);
    v0 = nv; f0 = nf;
    send(8'h55, 1'b1, ^8'h55);
    idle(10);
    check("t1_data", dataOut, 8'h55);
    check("t1_model_data", e_data, 8'h55);
    check("t1_nvalid", nv - v0, 1);
    check("t1_nferr", nf - f0, 0);
    check("t1_busy", busy, 1'b0);
    v0 = nv;
    send(8'hA3, 1'b1, ^8'hA3);
    check("t2_first", dataOut, 8'hA3);
    send(8'h3C, 1'b1, ^8'h3C);
    idle(10);
    check("t2_second", dataOut, 8'h3C);
    check("t2_nvalid", nv - v0, 2);
    v0 = nv; f0 = nf; p0 = np; saw_busy = 0;
    rx = 1'b0;
    repeat (5 * 4) @(negedge clk);
    idle(100);
    check("t3_saw_busy", saw_busy, 1'b1);
    check("t3_busy_end", busy, 1'b0);
    check("t3_pulses", (nv - v0) + (nf - f0) + (np - p0), 0);
    v0 = nv; f0 = nf;
    send(8'h81, 1'b0, ^8'h81);
    rx = 1'b0;
    repeat (3 * BITCLK) @(negedge clk);
    idle(100);
    check("t4_nferr", nf - f0, 1);
    check("t4_nvalid", nv - v0, 0);
    check("t4_data_kept", dataOut, 8'h3C);
    send(8'h42, 1'b1, ^8'h42);
    idle(10);
    check("t4_next", dataOut, 8'h42);
    fork
      send(8'hFF, 1'b1, ^8'hFF);
      begin
        repeat (3 * BITCLK) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("t5_rst_data", dataOut, 8'h00);
        check("t5_rst_busy", busy, 1'b0);
        rst = 1'b0;
      end
    join
    idle(30);
    check("t5_idle", busy, 1'b0);
    send(8'h12, 1'b1, ^8'h12);
    idle(10);
    check("t5_next", dataOut, 8'h12);
    if (PB == 1) begin
      v0 = nv; p0 = np;
      send(8'h07, 1'b1, 1'b1);
      idle(10);
      check("t6_good", dataOut, 8'h07);
      check("t6_nvalid", nv - v0, 1);
      send(8'h07, 1'b1, 1'b0);
      idle(10);
      check("t6_nperr", np - p0, 1);
      check("t6_nvalid2", nv - v0, 1);
    end
    for (int i = 0; i < 36; i++) begin
      b = 8'($urandom);
      repeat ($urandom_range(0, 3)) @(negedge clk);
      if ($urandom_range(0, 7) == 0) begin
        rx = 1'b0;
        repeat ($urandom_range(1, 40)) @(negedge clk);
        idle($urandom_range(40, 120));
      end
      send(b, $urandom_range(0, 5) != 0, (^b) ^ ($urandom_range(0, 6) == 0));
      idle($urandom_range(0, 150));
    end
    idle(200);
    check("end_busy", busy, 1'b0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end
endmodule
